ifft_dac_player: RTL and testbench
==================================

Name: ifft_dac_player

Overview:
- Downstream stage of the FFT → spectral multiply → IFFT chain.
- Captures one complete IFFT output frame (real part) into a ping-pong buffer, then scales, saturates and offsets each sample to the 10-bit DAC code.
- Replays the last good frame cyclically to the DAC at a programmable rate.
- A newly captured frame replaces the playing one only at a playback wrap, so DAC output never glitches mid-frame.

Parameters:
- FRAME_LEN, 4096, samples per IFFT frame (power of 2).
- ADDR_W, 12, log2(FRAME_LEN).
- IN_W, 33, width of the signed IFFT real output.
- SHIFT, 6, arithmetic right shift applied before saturation.

Ports:
- fft_clk  input  1  single clock for the whole block.
- sys_rst_n  input  1  reset, asynchronous assert, active-low.
- capture_start  input  1  rising edge arms capture of the next frame.
- ifft_real  input  IN_W  signed IFFT real output sample.
- ifft_valid  input  1  sample valid; no backpressure, always accepted.
- ifft_last  input  1  last sample of frame, qualified by ifft_valid.
- play_div  input  16  DAC sample period minus 1, in fft_clk cycles.
- da_data  output  10  offset-binary DAC code.
- play_active  output  1  a valid frame is being replayed.
- capturing  output  1  armed or capturing.
- frame_err  output  1  sticky; the last capture had the wrong length.
- sat_cnt  output  16  saturated samples in the last accepted frame.

Behaviour:
- Reset values: da_data=10'd512, play_active=0, capturing=0, frame_err=0, sat_cnt=0; FSM=IDLE; front bank=0; all counters 0.
- Capture FSM states: IDLE, ARM, CAPTURE, WAIT_SWAP.
  - IDLE: a capture_start rising edge (registered edge detect) moves to ARM and clears frame_err.
  - Edges are ignored in every state except IDLE.
  - ARM: the first ifft_valid writes the sample at address 0 of the back bank, then moves to CAPTURE with wcnt=1.
  - If that first sample also has ifft_last: frame_err=1, return to IDLE.
  - CAPTURE: each ifft_valid writes the back bank at wcnt, then wcnt increments.
  - Frame accepted: ifft_last arrives with wcnt==FRAME_LEN-1. Go to WAIT_SWAP.
  - Early last (wcnt<FRAME_LEN-1): frame_err=1, frame discarded, go to IDLE.
  - wcnt==FRAME_LEN-1 without last: frame_err=1, frame discarded, go to IDLE; later samples ignored.
  - WAIT_SWAP, play_active=0: swap immediately on the next cycle and set play_active=1.
  - WAIT_SWAP, play_active=1: swap on the cycle the read address wraps FRAME_LEN-1→0.
  - After either swap, go to IDLE.
- capturing=1 in ARM and CAPTURE.
- Conversion, done on write and stored as 10-bit code:
  - v = ifft_real >>> SHIFT (sign-preserving).
  - Saturate v to [-512, 511].
  - code = v + 512, unsigned.
- Saturation counting:
  - A per-frame counter increments on each saturated sample and saturates at 16'hFFFF.
  - It is copied to sat_cnt at swap.
  - It is cleared at entry to ARM.
- Playback:
  - Runs only when play_active=1.
  - A divider counter counts 0..play_div; at terminal count raddr increments, wrapping FRAME_LEN-1→0.
  - play_div=0 advances raddr every cycle.
  - play_div changes take effect at the next terminal count.
  - Buffer read has 1-cycle latency; da_data is registered.
  - da_data therefore updates 2 cycles after the raddr increment.
  - The first swap starts playback at raddr=0; the first code appears 2 cycles later.
  - Before any accepted frame, da_data holds 512.
  - A swap during playback changes the bank at the wrap, so sample 0 of the new frame follows sample FRAME_LEN-1 of the old frame.
- Simultaneous events:
  - Frame accept and wrap in the same cycle: swap waits for the next wrap. The accept registers WAIT_SWAP first.
  - A capture_start edge during WAIT_SWAP is ignored.
- Reset mid-operation: all state returns to reset values immediately. Buffer contents are don't-care, and play_active=0 prevents their use.

Test Plan:
- Use FRAME_LEN=16, ADDR_W=4, SHIFT=6, play_div=2. Edge on capture_start, then 16 valids of ifft_real=k*64 (k=0..15) with last on the 16th. Required: play_active rises; da_data cycles 512,513,...,527, each held 3 cycles, wrapping to 512.
- Saturation: samples of +40000 and -40000 (v=625, -625). Required: codes 1023 and 0 stored; sat_cnt=2 after swap.
- Early last on the 10th sample. Required: frame_err=1, FSM returns to IDLE, playback of the previous frame unchanged, capturing=0.
- Second frame during playback: codes 600..615 captured while frame 1 is mid-play. Required: frame 1 completes to sample 15, the next output is 600, no mixed samples.
- capture_start pulses during CAPTURE and WAIT_SWAP. Required: ignored, no re-arm, frame captured intact.
- Assert sys_rst_n=0 mid-capture with playback active. Required: da_data=512 and play_active=0 immediately; after release, no output change until a new full frame is accepted.

Source files
------------

// File: rtl/ifft_dac_player.sv
// ifft_dac_player: captures one IFFT frame into a ping-pong buffer as DAC codes
// and replays the last good frame cyclically, swapping banks only at a wrap.
module ifft_dac_player #(
  parameter int FRAME_LEN = 4096,
  parameter int ADDR_W    = 12,
  parameter int IN_W      = 33,
  parameter int SHIFT     = 6
) (
  input  logic              fft_clk,
  input  logic              sys_rst_n,
  input  logic              capture_start,
  input  logic [IN_W-1:0]   ifft_real,
  input  logic              ifft_valid,
  input  logic              ifft_last,
  input  logic [15:0]       play_div,
  output logic [9:0]        da_data,
  output logic              play_active,
  output logic              capturing,
  output logic              frame_err,
  output logic [15:0]       sat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_LEN - 1);
  localparam logic signed [IN_W-1:0] V_MAX = IN_W'(511);
  localparam logic signed [IN_W-1:0] V_MIN = IN_W'(-512);

  logic [9:0] mem [2*FRAME_LEN];

  logic [1:0]        state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              front_q, front_d;
  logic              err_q, err_d;
  logic [15:0]       satc_q, satc_d;
  logic [15:0]       sat_q, sat_d;
  logic              play_q, play_d;
  logic [15:0]       div_q, div_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [9:0]        rdata_q;
  logic              rvld_q;
  logic [9:0]        da_q;

  logic              start_edge;
  logic              tc;
  logic              wrap;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic signed [IN_W-1:0] v;
  logic [9:0]        code;
  logic              is_sat;

  assign start_edge = capture_start && !start_q;
  assign tc         = play_q && (div_q >= play_div);
  assign wrap       = tc && (raddr_q == LAST_A);

  // Shift, saturate and offset the incoming sample into a DAC code.
  always_comb begin
    v      = $signed(ifft_real) >>> SHIFT;
    code   = {~v[9], v[8:0]};
    is_sat = 1'b0;
    if (v > V_MAX) begin
      code   = 10'h3FF;
      is_sat = 1'b1;
    end else if (v < V_MIN) begin
      code   = 10'h000;
      is_sat = 1'b1;
    end
  end

  // Capture FSM, playback divider/address and bank swap.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    front_d = front_q;
    err_d   = err_q;
    satc_d  = satc_q;
    sat_d   = sat_q;
    play_d  = play_q;
    div_d   = div_q;
    raddr_d = raddr_q;
    we      = 1'b0;
    waddr   = wcnt_q;
    if (play_q) begin
      if (tc) begin
        div_d   = '0;
        raddr_d = raddr_q + 1'b1;
      end else begin
        div_d   = div_q + 16'd1;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_ARM;
          err_d   = 1'b0;
          satc_d  = '0;
          wcnt_d  = '0;
        end
      end
      S_ARM: begin
        if (ifft_valid) begin
          we    = 1'b1;
          waddr = '0;
          if (ifft_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wcnt_d  = ADDR_W'(1);
            state_d = S_CAP;
          end
        end
      end
      S_CAP: begin
        if (ifft_valid) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_A) begin
            if (ifft_last) begin
              state_d = S_WAIT;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else if (ifft_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (!play_q || wrap) begin
          front_d = ~front_q;
          play_d  = 1'b1;
          sat_d   = satc_q;
          state_d = S_IDLE;
          if (!play_q) begin
            div_d   = '0;
            raddr_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (we && is_sat && (satc_q != 16'hFFFF)) begin
      satc_d = satc_q + 16'd1;
    end
  end

  // Control and status registers.
  always_ff @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      wcnt_q  <= '0;
      front_q <= 1'b0;
      err_q   <= 1'b0;
      satc_q  <= '0;
      sat_q   <= '0;
      play_q  <= 1'b0;
      div_q   <= '0;
      raddr_q <= '0;
      rvld_q  <= 1'b0;
      da_q    <= 10'd512;
    end else begin
      state_q <= state_d;
      start_q <= capture_start;
      wcnt_q  <= wcnt_d;
      front_q <= front_d;
      err_q   <= err_d;
      satc_q  <= satc_d;
      sat_q   <= sat_d;
      play_q  <= play_d;
      div_q   <= div_d;
      raddr_q <= raddr_d;
      rvld_q  <= play_q;
      da_q    <= rvld_q ? rdata_q : 10'd512;
    end
  end

  // Ping-pong buffer: write the back bank, read the front bank.
  always_ff @(posedge fft_clk) begin
    if (we) begin
      mem[{~front_q, waddr}] <= code;
    end
    rdata_q <= mem[{front_q, raddr_q}];
  end

  assign da_data     = da_q;
  assign play_active = play_q;
  assign capturing   = (state_q == S_ARM) || (state_q == S_CAP);
  assign frame_err   = err_q;
  assign sat_cnt     = sat_q;

endmodule

// File: tb/tb_ifft_dac_player.sv
// tb_ifft_dac_player: directed frames against a frame-level playback model,
// checked every cycle, plus literal checks of the key sequences.
module tb_ifft_dac_player;

  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic [32:0] ir = '0;
  logic        iv = 1'b0;
  logic        il = 1'b0;
  logic [15:0] pdiv = 16'd2;
  logic [9:0]  da;
  logic        pa;
  logic        capg;
  logic        ferr;
  logic [15:0] satc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifft_dac_player #(
    .FRAME_LEN(FL),
    .ADDR_W(4),
    .IN_W(33),
    .SHIFT(6)
  ) dut (
    .fft_clk(clk),
    .sys_rst_n(rst_n),
    .capture_start(cs),
    .ifft_real(ir),
    .ifft_valid(iv),
    .ifft_last(il),
    .play_div(pdiv),
    .da_data(da),
    .play_active(pa),
    .capturing(capg),
    .frame_err(ferr),
    .sat_cnt(satc)
  );

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int to_code(input int x);
    int v;
    v = x >>> 6;
    if (v > 511) v = 511;
    if (v < -512) v = -512;
    return v + 512;
  endfunction

  function automatic bit clipped(input int x);
    int v;
    v = x >>> 6;
    return (v > 511) || (v < -512);
  endfunction

  function automatic int samp(input int kind, input int k);
    case (kind)
      0:       return k * 64;
      1:       return (88 + k) * 64;
      default: return (k == 0) ? 40000 : (k == 1) ? -40000 : 0;
    endcase
  endfunction

  // Frame-level model: frames held as arrays, playback as a sample
  // index with a hold countdown, output seen two cycles late.
  bit m_play = 0, m_wait = 0, m_cap = 0, m_err = 0, prev_start = 0;
  int m_da = 512, c1 = 512, pos = 0, rem = 0;
  int m_sat = 0, cnt = 0, pend_sat = 0;
  int cur [FL];
  int pend [FL];
  int capq [$];

  initial begin
    bit o_play, o_wait, o_cap, wrap;
    int x;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_play = 0; m_wait = 0; m_cap = 0; m_err = 0;
        prev_start = 0; m_da = 512; c1 = 512;
        pos = 0; rem = 0; m_sat = 0; cnt = 0;
        capq.delete();
      end else begin
        o_play = m_play;
        o_wait = m_wait;
        o_cap  = m_cap;
        m_da = c1;
        c1 = o_play ? cur[pos] : 512;
        wrap = 0;
        if (o_play) begin
          if (rem == 0) begin
            wrap = (pos == FL - 1);
            pos = (pos + 1) % FL;
            rem = int'(pdiv);
          end else begin
            rem--;
          end
        end
        if (o_wait && (!o_play || wrap)) begin
          cur = pend;
          m_sat = pend_sat;
          m_play = 1;
          m_wait = 0;
          if (!o_play) begin
            pos = 0;
            rem = int'(pdiv);
          end
        end
        if (o_cap) begin
          if (iv) begin
            x = $signed(ir[31:0]);
            capq.push_back(to_code(x));
            if (clipped(x) && cnt < 65535) cnt++;
            if (il || capq.size() == FL) begin
              m_cap = 0;
              if (il && capq.size() == FL) begin
                for (int i = 0; i < FL; i++) pend[i] = capq[i];
                pend_sat = cnt;
                m_wait = 1;
              end else begin
                m_err = 1;
              end
            end
          end
        end else if (!o_wait && cs && !prev_start) begin
          m_cap = 1;
          m_err = 0;
          cnt = 0;
          capq.delete();
        end
        prev_start = cs;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("da_data", int'(da), m_da);
      chk("play_active", int'(pa), int'(m_play));
      chk("capturing", int'(capg), int'(m_cap));
      chk("frame_err", int'(ferr), int'(m_err));
      chk("sat_cnt", int'(satc), m_sat);
    end
  end

  task automatic send(input int n, input int kind, input int pulse_at);
    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iv = 1'b1;
      il = (i == n - 1);
      ir = 33'(samp(kind, i));
      cs = (i == pulse_at);
    end
    @(negedge clk);
    iv = 1'b0; il = 1'b0; ir = '0; cs = 1'b0;
  endtask

  task automatic wait_play();
    int t = 0;
    while (!pa && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("play_rise", int'(pa), 1);
  endtask

  task automatic wait_val(input int val, output int prev);
    int t = 0;
    bit ok = 0;
    prev = int'(da);
    while (t < 300) begin
      @(negedge clk);
      t++;
      if (int'(da) == val) begin
        ok = 1;
        break;
      end
      prev = int'(da);
    end
    chk("wait_code", int'(ok), 1);
  endtask

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    chk("rst_da", int'(da), 512);
    chk("rst_play", int'(pa), 0);
    chk("rst_capt", int'(capg), 0);
    chk("rst_err", int'(ferr), 0);
    chk("rst_sat", int'(satc), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("conv_hi", to_code(40000), 1023);
    chk("conv_lo", to_code(-40000), 0);
    chk("conv_mid", to_code(960), 527);

    send(FL, 0, -1);
    wait_play();
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      chk("play_a", int'(da), (i < 2) ? 512 : 512 + ((i - 2) / 3) % FL);
    end

    send(FL, 1, 5);
    if (m_wait) begin
      cs = 1'b1;
      @(negedge clk);
      cs = 1'b0;
    end
    wait_val(600, prev);
    chk("b_after_a", prev, 527);
    repeat (5) @(negedge clk);
    chk("no_rearm", int'(capg), 0);
    chk("b_err", int'(ferr), 0);

    send(10, 0, -1);
    chk("early_err", int'(ferr), 1);
    chk("early_capt", int'(capg), 0);
    chk("early_play", int'(pa), 1);
    repeat (10) @(negedge clk);

    send(FL + 1, 0, -1);
    chk("long_err", int'(ferr), 1);
    chk("long_capt", int'(capg), 0);
    repeat (10) @(negedge clk);

    send(FL, 2, -1);
    wait_val(1023, prev);
    chk("sat_after_b", prev, 615);
    wait_val(0, prev);
    chk("sat_seq", prev, 1023);
    chk("sat_cnt2", int'(satc), 2);
    chk("sat_err", int'(ferr), 0);

    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv = 1'b1;
      ir = 33'(samp(1, i));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    iv = 1'b0;
    ir = '0;
    #1;
    chk("mid_rst_da", int'(da), 512);
    chk("mid_rst_play", int'(pa), 0);
    chk("mid_rst_capt", int'(capg), 0);
    chk("mid_rst_sat", int'(satc), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("idle_da", int'(da), 512);
    chk("idle_play", int'(pa), 0);

    send(FL, 1, -1);
    wait_play();
    @(negedge clk);
    chk("resume_wait", int'(da), 512);
    @(negedge clk);
    chk("resume_first", int'(da), 600);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
